// File: rtl/wb_load_store_unit.sv
// wb_load_store_unit
// Runs one RV32 load/store request as one or two single-beat Wishbone B4
// cycles. Accesses that straddle a bus word are split into two beats (or
// rejected when MISALIGN_SPLIT=0). Handles RTY re-issue and silent-slave
// timeouts, and returns an aligned, sign/zero-extended load result.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   memory_operation    LOAD_DATA / STORE_DATA, anything else is a no-op
//   cyc                 request strobe (sampled in IDLE only)
//   funct3, address     RV32 access width/sign and byte address
//   store_data          store operand (low bytes used)
//   ack / err / data_valid  one-cycle pulses: accepted / failed / completed
//   load_data           load result, held until the next load completes
//   ACK ERR RTY DAT_I   Wishbone slave response and read data
//   CYC STB WE ADR DAT_O SEL_O CTI_O  Wishbone master side

package wb_lsu_pkg;
  typedef enum logic [1:0] {
    MEM_NOP    = 2'b00,
    LOAD_DATA  = 2'b01,
    STORE_DATA = 2'b10
  } memory_operation_t;
endpackage

module wb_load_store_unit
  import wb_lsu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int MISALIGN_SPLIT = 1,
  parameter int MAX_RETRY      = 4,
  parameter int TIMEOUT        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  memory_operation_t       memory_operation,
  input  logic                    cyc,
  output logic                    ack,
  output logic                    err,
  output logic                    data_valid,
  input  logic [2:0]              funct3,
  input  logic [31:0]             store_data,
  input  logic [ADDR_WIDTH-1:0]   address,
  output logic [31:0]             load_data,
  input  logic                    ACK,
  input  logic                    ERR,
  input  logic                    RTY,
  output logic                    STB,
  output logic                    CYC,
  output logic                    WE,
  output logic [ADDR_WIDTH-1:0]   ADR,
  input  logic [DATA_WIDTH-1:0]   DAT_I,
  output logic [DATA_WIDTH-1:0]   DAT_O,
  output logic [DATA_WIDTH/8-1:0] SEL_O,
  output logic [2:0]              CTI_O
);

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(BYTES);
  localparam int RTY_W     = $clog2(MAX_RETRY + 1) + 1;
  localparam int TMO_W     = $clog2(TIMEOUT + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BEAT1 = 3'd1,
    S_BEAT2 = 3'd2,
    S_DONE  = 3'd3,
    S_FAIL  = 3'd4
  } state_t;

  // Byte-enable pattern for the access size, before lane shifting.
  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      2'b10:   size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  endfunction

  // Bit mask covering the store bytes that are actually written.
  function automatic logic [31:0] data_mask(input logic [2:0] f3);
    logic [3:0] m;
    m = size_mask(f3);
    for (int i = 0; i < 4; i++) begin
      data_mask[8*i +: 8] = {8{m[i]}};
    end
  endfunction

  function automatic logic is_legal(input logic store, input logic [2:0] f3);
    if (store) begin
      case (f3)
        3'b000, 3'b001, 3'b010: is_legal = 1'b1;
        default:                is_legal = 1'b0;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: is_legal = 1'b1;
        default:                                is_legal = 1'b0;
      endcase
    end
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      3'b000:  extend = {{24{w[7]}}, w[7:0]};
      3'b001:  extend = {{16{w[15]}}, w[15:0]};
      3'b100:  extend = {24'h000000, w[7:0]};
      3'b101:  extend = {16'h0000, w[15:0]};
      default: extend = w;
    endcase
  endfunction

  state_t                  state_r, next_state_s;
  logic                    store_r;
  logic [2:0]              funct3_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [31:0]             sdata_r;
  logic [RTY_W-1:0]        retry_r, retry_nx_s;
  logic [TMO_W-1:0]        timer_r, timer_nx_s;
  logic [DATA_WIDTH-1:0]   rdata_lo_r, rdata_lo_nx_s;
  logic [DATA_WIDTH-1:0]   rdata_hi_r, rdata_hi_nx_s;

  logic                    latch_s;
  logic                    is_ls_s, is_store_in_s;
  logic [2:0]              src_f3_s;
  logic [ADDR_WIDTH-1:0]   src_addr_s;
  logic [31:0]             src_sd_s;
  logic [LANE_BITS-1:0]    src_off_s;
  logic [2*BYTES-1:0]      lane_sel_s;
  logic [2*DATA_WIDTH-1:0] lane_dat_s;
  logic                    split_s;
  logic [ADDR_WIDTH-1:0]   base_s;
  logic [31:0]             word_s;

  logic                    ack_nx_s, err_nx_s, dv_nx_s;
  logic                    cyc_nx_s, stb_nx_s, we_nx_s;
  logic [ADDR_WIDTH-1:0]   adr_nx_s;
  logic [DATA_WIDTH-1:0]   dat_nx_s;
  logic [BYTES-1:0]        sel_nx_s;
  logic [2:0]              cti_nx_s;
  logic [31:0]             load_nx_s;

  assign is_store_in_s = (memory_operation == STORE_DATA);
  assign is_ls_s       = (memory_operation == LOAD_DATA) || is_store_in_s;

  // Lane plan for the current request: taken straight from the inputs while
  // idle (so beat 1 can be launched on the accepting edge), else from the latch.
  always_comb begin
    if (state_r == S_IDLE) begin
      src_f3_s   = funct3;
      src_addr_s = address;
      src_sd_s   = store_data;
    end else begin
      src_f3_s   = funct3_r;
      src_addr_s = addr_r;
      src_sd_s   = sdata_r;
    end
    src_off_s  = src_addr_s[LANE_BITS-1:0];
    lane_sel_s = {{(2*BYTES-4){1'b0}}, size_mask(src_f3_s)} << src_off_s;
    lane_dat_s = {{(2*DATA_WIDTH-32){1'b0}}, src_sd_s & data_mask(src_f3_s)}
                 << {src_off_s, 3'b000};
    split_s    = |lane_sel_s[2*BYTES-1:BYTES];
    base_s     = {src_addr_s[ADDR_WIDTH-1:LANE_BITS], {LANE_BITS{1'b0}}};
  end

  // Both captured beats concatenated in address order, shifted down to byte 0.
  assign word_s = 32'({rdata_hi_r, rdata_lo_r} >> {addr_r[LANE_BITS-1:0], 3'b000});

  // Next-state and next-output logic of the access FSM.
  always_comb begin
    next_state_s  = state_r;
    latch_s       = 1'b0;
    ack_nx_s      = 1'b0;
    err_nx_s      = 1'b0;
    dv_nx_s       = 1'b0;
    cyc_nx_s      = CYC;
    stb_nx_s      = STB;
    we_nx_s       = WE;
    adr_nx_s      = ADR;
    dat_nx_s      = DAT_O;
    sel_nx_s      = SEL_O;
    cti_nx_s      = CTI_O;
    load_nx_s     = load_data;
    retry_nx_s    = retry_r;
    timer_nx_s    = timer_r;
    rdata_lo_nx_s = rdata_lo_r;
    rdata_hi_nx_s = rdata_hi_r;

    case (state_r)
      S_IDLE: begin
        if (cyc && is_ls_s) begin
          latch_s  = 1'b1;
          ack_nx_s = 1'b1;
          if (!is_legal(is_store_in_s, funct3) || (split_s && (MISALIGN_SPLIT == 0))) begin
            next_state_s = S_FAIL;
          end else begin
            next_state_s = S_BEAT1;
            cyc_nx_s     = 1'b1;
            stb_nx_s     = 1'b1;
            we_nx_s      = is_store_in_s;
            adr_nx_s     = base_s;
            sel_nx_s     = lane_sel_s[BYTES-1:0];
            dat_nx_s     = lane_dat_s[DATA_WIDTH-1:0];
            cti_nx_s     = split_s ? 3'b010 : 3'b000;
            retry_nx_s   = '0;
            timer_nx_s   = '0;
          end
        end else begin
          next_state_s = S_IDLE;
        end
      end

      S_BEAT1, S_BEAT2: begin
        if (!STB) begin
          // One-cycle STB gap after RTY or between beats: re-issue now.
          stb_nx_s = 1'b1;
        end else if (ERR) begin
          cyc_nx_s     = 1'b0;
          stb_nx_s     = 1'b0;
          we_nx_s      = 1'b0;
          err_nx_s     = 1'b1;
          next_state_s = S_IDLE;
        end else if (ACK) begin
          if (state_r == S_BEAT1) begin
            rdata_lo_nx_s = DAT_I;
          end else begin
            rdata_hi_nx_s = DAT_I;
          end
          retry_nx_s = '0;
          timer_nx_s = '0;
          if ((state_r == S_BEAT1) && split_s) begin
            next_state_s = S_BEAT2;
            stb_nx_s     = 1'b0;
            adr_nx_s     = base_s + ADDR_WIDTH'(BYTES);
            sel_nx_s     = lane_sel_s[2*BYTES-1:BYTES];
            dat_nx_s     = lane_dat_s[2*DATA_WIDTH-1:DATA_WIDTH];
            cti_nx_s     = 3'b111;
          end else begin
            next_state_s = S_DONE;
            cyc_nx_s     = 1'b0;
            stb_nx_s     = 1'b0;
            we_nx_s      = 1'b0;
          end
        end else if (RTY) begin
          if (retry_r >= RTY_W'(MAX_RETRY)) begin
            cyc_nx_s     = 1'b0;
            stb_nx_s     = 1'b0;
            we_nx_s      = 1'b0;
            err_nx_s     = 1'b1;
            next_state_s = S_IDLE;
          end else begin
            retry_nx_s = retry_r + RTY_W'(1);
            timer_nx_s = '0;
            stb_nx_s   = 1'b0;
          end
        end else if (timer_r >= TMO_W'(TIMEOUT - 1)) begin
          cyc_nx_s     = 1'b0;
          stb_nx_s     = 1'b0;
          we_nx_s      = 1'b0;
          err_nx_s     = 1'b1;
          next_state_s = S_IDLE;
        end else begin
          timer_nx_s = timer_r + TMO_W'(1);
        end
      end

      S_DONE: begin
        if (!store_r) begin
          load_nx_s = extend(funct3_r, word_s);
        end else begin
          load_nx_s = load_data;
        end
        dv_nx_s      = 1'b1;
        next_state_s = S_IDLE;
      end

      S_FAIL: begin
        err_nx_s     = 1'b1;
        next_state_s = S_IDLE;
      end

      default: begin
        cyc_nx_s     = 1'b0;
        stb_nx_s     = 1'b0;
        we_nx_s      = 1'b0;
        next_state_s = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Request latch, per-beat counters, read capture and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      store_r    <= 1'b0;
      funct3_r   <= 3'b000;
      addr_r     <= '0;
      sdata_r    <= 32'h0000_0000;
      retry_r    <= '0;
      timer_r    <= '0;
      rdata_lo_r <= '0;
      rdata_hi_r <= '0;
      ack        <= 1'b0;
      err        <= 1'b0;
      data_valid <= 1'b0;
      CYC        <= 1'b0;
      STB        <= 1'b0;
      WE         <= 1'b0;
      ADR        <= '0;
      DAT_O      <= '0;
      SEL_O      <= '0;
      CTI_O      <= 3'b000;
      load_data  <= 32'h0000_0000;
    end else begin
      if (latch_s) begin
        store_r  <= is_store_in_s;
        funct3_r <= funct3;
        addr_r   <= address;
        sdata_r  <= store_data;
      end
      retry_r    <= retry_nx_s;
      timer_r    <= timer_nx_s;
      rdata_lo_r <= rdata_lo_nx_s;
      rdata_hi_r <= rdata_hi_nx_s;
      ack        <= ack_nx_s;
      err        <= err_nx_s;
      data_valid <= dv_nx_s;
      CYC        <= cyc_nx_s;
      STB        <= stb_nx_s;
      WE         <= we_nx_s;
      ADR        <= adr_nx_s;
      DAT_O      <= dat_nx_s;
      SEL_O      <= sel_nx_s;
      CTI_O      <= cti_nx_s;
      load_data  <= load_nx_s;
    end
  end

endmodule

// File: tb/tb_wb_load_store_unit.sv
// Directed bench for wb_load_store_unit: a 32-bit split-enabled unit with a
// scriptable slave (RTY count, silence, ERR), a 32-bit unit without splitting,
// and a 64-bit unit. A monitor logs beats and pulses per request.
module tb_wb_load_store_unit;
  import wb_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  memory_operation_t op;
  logic [2:0]  f3;
  logic [31:0] addr, sd;
  logic        cyc, cyc1, cyc2;

  // ---------------- unit 0: 32-bit, split enabled ----------------
  logic        ack, err, dv, ACK, ERR, RTY, STB, CYC, WE;
  logic [31:0] ld, ADR, DAT_I, DAT_O;
  logic [3:0]  SEL_O;
  logic [2:0]  CTI_O;
  logic [31:0] mem [16];
  logic        silent, err_mode;
  int          rty_target, rty_seen;

  assign DAT_I = mem[ADR[5:2]];
  assign ERR   = STB && err_mode;
  assign RTY   = STB && !silent && !err_mode && (rty_seen < rty_target);
  assign ACK   = STB && !silent && (rty_seen >= rty_target);

  wb_load_store_unit u0 (
    .clk(clk), .rst(rst), .memory_operation(op), .cyc(cyc), .ack(ack), .err(err),
    .data_valid(dv), .funct3(f3), .store_data(sd), .address(addr), .load_data(ld),
    .ACK(ACK), .ERR(ERR), .RTY(RTY), .STB(STB), .CYC(CYC), .WE(WE), .ADR(ADR),
    .DAT_I(DAT_I), .DAT_O(DAT_O), .SEL_O(SEL_O), .CTI_O(CTI_O)
  );

  // ---------------- unit 1: 32-bit, no split ----------------
  logic        ack1, err1, dv1, STB1, CYC1, WE1;
  logic [31:0] ld1, ADR1, DAT_O1;
  logic [3:0]  SEL1;
  logic [2:0]  CTI1;

  wb_load_store_unit #(.MISALIGN_SPLIT(0)) u1 (
    .clk(clk), .rst(rst), .memory_operation(op), .cyc(cyc1), .ack(ack1), .err(err1),
    .data_valid(dv1), .funct3(f3), .store_data(sd), .address(addr), .load_data(ld1),
    .ACK(STB1), .ERR(1'b0), .RTY(1'b0), .STB(STB1), .CYC(CYC1), .WE(WE1), .ADR(ADR1),
    .DAT_I(32'hCAFE_F00D), .DAT_O(DAT_O1), .SEL_O(SEL1), .CTI_O(CTI1)
  );

  // ---------------- unit 2: 64-bit ----------------
  logic        ack2, err2, dv2, STB2, CYC2, WE2;
  logic [31:0] ld2, ADR2;
  logic [63:0] DAT_I2, DAT_O2;
  logic [7:0]  SEL2;
  logic [2:0]  CTI2;

  assign DAT_I2 = (ADR2 == 32'h0000_1000) ? 64'h8877_6655_4433_2211 : 64'hFFEE_DDCC_BBAA_9988;

  wb_load_store_unit #(.DATA_WIDTH(64)) u2 (
    .clk(clk), .rst(rst), .memory_operation(op), .cyc(cyc2), .ack(ack2), .err(err2),
    .data_valid(dv2), .funct3(f3), .store_data(sd), .address(addr), .load_data(ld2),
    .ACK(STB2), .ERR(1'b0), .RTY(1'b0), .STB(STB2), .CYC(CYC2), .WE(WE2), .ADR(ADR2),
    .DAT_I(DAT_I2), .DAT_O(DAT_O2), .SEL_O(SEL2), .CTI_O(CTI2)
  );

  // ---------------- monitors (counters restart when a request is sampled) ----
  logic [31:0] b_adr [4];
  logic [31:0] b_dat [4];
  logic [3:0]  b_sel [4];
  logic [2:0]  b_cti [4];
  logic        b_we  [4];
  int n_beats, n_dv, n_err, n_ack, n_stb;
  int cycle_no, req_edge, dv_edge, err_edge, stb_edge;
  logic stb_prev = 1'b0;
  logic cyc_seen = 1'b0;
  int n_err1, n_dv1, n_b2, n_dv2;
  logic cyc1_seen = 1'b0;
  logic [7:0]  b2_sel [2];
  logic [31:0] b2_adr [2];

  always @(posedge clk) begin
    cycle_no <= cycle_no + 1;
    stb_prev <= STB;
    rty_seen <= CYC ? rty_seen + ((STB && RTY) ? 1 : 0) : 0;
    if (cyc) begin
      n_beats <= 0; n_dv <= 0; n_err <= 0; n_ack <= 0; n_stb <= 0;
      cyc_seen <= 1'b0; req_edge <= cycle_no;
    end else begin
      if (STB && !stb_prev) begin
        n_stb <= n_stb + 1;
        if (n_stb == 0) stb_edge <= cycle_no;
      end
      if (CYC) cyc_seen <= 1'b1;
      if (dv) begin n_dv <= n_dv + 1; dv_edge <= cycle_no; end
      if (err) begin n_err <= n_err + 1; err_edge <= cycle_no; end
      if (ack) n_ack <= n_ack + 1;
      if (STB && ACK && !ERR && n_beats < 4) begin
        b_adr[n_beats[1:0]] <= ADR;
        b_dat[n_beats[1:0]] <= DAT_O;
        b_sel[n_beats[1:0]] <= SEL_O;
        b_cti[n_beats[1:0]] <= CTI_O;
        b_we[n_beats[1:0]]  <= WE;
        n_beats <= n_beats + 1;
      end
    end
    if (cyc1) begin
      n_err1 <= 0; n_dv1 <= 0; cyc1_seen <= 1'b0;
    end else begin
      if (err1) n_err1 <= n_err1 + 1;
      if (dv1) n_dv1 <= n_dv1 + 1;
      if (CYC1) cyc1_seen <= 1'b1;
    end
    if (cyc2) begin
      n_dv2 <= 0; n_b2 <= 0;
    end else begin
      if (dv2) n_dv2 <= n_dv2 + 1;
      if (STB2 && n_b2 < 2) begin
        b2_sel[n_b2[0]] <= SEL2;
        b2_adr[n_b2[0]] <= ADR2;
        n_b2 <= n_b2 + 1;
      end
    end
  end

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Pulse cyc for one sampled edge on the selected unit; returns at the
  // negedge following the accepting edge.
  task automatic req(input int which, input memory_operation_t o, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    op = o; f3 = f; addr = a; sd = d;
    if (which == 0) cyc = 1'b1;
    else if (which == 1) cyc1 = 1'b1;
    else cyc2 = 1'b1;
    @(negedge clk);
    cyc = 1'b0; cyc1 = 1'b0; cyc2 = 1'b0; op = MEM_NOP;
  endtask

  // Wait (bounded) for unit 0 to finish, then a few idle cycles for stray pulses.
  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while ((n_dv + n_err) == 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_finished"}, 64'((n_dv + n_err) > 0), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; cyc = 1'b0; cyc1 = 1'b0; cyc2 = 1'b0; op = MEM_NOP;
    f3 = 3'b000; addr = 32'h0; sd = 32'h0;
    silent = 1'b0; err_mode = 1'b0; rty_target = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'h4433_2211;
    mem[1] = 32'h8877_6655;
    mem[2] = 32'h0080_3311;
    mem[3] = 32'h0000_9ABC;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {CYC, STB, WE, ack, err, dv}, 64'd0);
    chk("rst_adr_sel_cti", {ADR, SEL_O, CTI_O}, 64'd0);
    chk("rst_dat_ld", {DAT_O, ld}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Split LW across 0x1000/0x1004
    req(0, LOAD_DATA, 3'b010, 32'h1003, 32'h0);
    wait_done("lw_split", 20);
    chk("lw_split_beats", n_beats, 2);
    chk("lw_split_b1", {b_adr[0], b_sel[0], b_cti[0]}, {32'h1000, 4'b1000, 3'b010});
    chk("lw_split_b2", {b_adr[1], b_sel[1], b_cti[1]}, {32'h1004, 4'b0111, 3'b111});
    chk("lw_split_data", ld, 32'h7766_5544);
    chk("lw_split_dv_pulses", n_dv, 1);
    chk("lw_split_ack_pulses", n_ack, 1);
    chk("lw_split_latency", dv_edge - req_edge, 5);
    chk("lw_split_stb_gap", n_stb, 2);

    // Aligned LW, zero-wait latency
    req(0, LOAD_DATA, 3'b010, 32'h1000, 32'h0);
    wait_done("lw_al", 20);
    chk("lw_al_data", ld, 32'h4433_2211);
    chk("lw_al_beat", {b_sel[0], b_cti[0]}, {4'b1111, 3'b000});
    chk("lw_al_latency", dv_edge - req_edge, 3);

    // Byte/half loads with sign handling (word 0x00803311 at 0x1008)
    req(0, LOAD_DATA, 3'b000, 32'h100A, 32'h0);
    wait_done("lb", 20);
    chk("lb_data", ld, 32'hFFFF_FF80);
    chk("lb_beat", {n_beats[3:0], b_sel[0], b_cti[0]}, {4'd1, 4'b0100, 3'b000});
    req(0, LOAD_DATA, 3'b100, 32'h100A, 32'h0);
    wait_done("lbu", 20);
    chk("lbu_data", ld, 32'h0000_0080);
    req(0, LOAD_DATA, 3'b001, 32'h1008, 32'h0);
    wait_done("lh_lo", 20);
    chk("lh_lo_data", ld, 32'h0000_3311);
    req(0, LOAD_DATA, 3'b001, 32'h100A, 32'h0);
    wait_done("lh", 20);
    chk("lh_data", ld, 32'h0000_0080);
    req(0, LOAD_DATA, 3'b001, 32'h100C, 32'h0);
    wait_done("lh_neg", 20);
    chk("lh_neg_data", ld, 32'hFFFF_9ABC);
    req(0, LOAD_DATA, 3'b101, 32'h100C, 32'h0);
    wait_done("lhu", 20);
    chk("lhu_data", ld, 32'h0000_9ABC);

    // Split SH store
    req(0, STORE_DATA, 3'b001, 32'h1003, 32'h0000_BEEF);
    wait_done("sh_split", 20);
    chk("sh_b1", {b_sel[0], b_dat[0][31:24], b_cti[0], b_we[0]}, {4'b1000, 8'hEF, 3'b010, 1'b1});
    chk("sh_b2", {b_adr[1], b_sel[1], b_dat[1][7:0], b_we[1]}, {32'h1004, 4'b0001, 8'hBE, 1'b1});
    chk("sh_ld_held", ld, 32'h0000_9ABC);
    chk("sh_dv_pulses", n_dv, 1);
    req(0, STORE_DATA, 3'b000, 32'h1001, 32'h1234_56AB);
    wait_done("sb", 20);
    chk("sb_beat", {b_sel[0], b_dat[0][15:8], b_we[0]}, {4'b0010, 8'hAB, 1'b1});

    // RTY twice then ACK
    rty_target = 2;
    req(0, LOAD_DATA, 3'b010, 32'h1000, 32'h0);
    wait_done("rty2", 40);
    chk("rty2_dv", n_dv, 1);
    chk("rty2_stb_issues", n_stb, 3);
    chk("rty2_data", ld, 32'h4433_2211);

    // RTY beyond MAX_RETRY
    rty_target = 9;
    req(0, LOAD_DATA, 3'b010, 32'h1004, 32'h0);
    wait_done("rty5", 40);
    chk("rty5_err", n_err, 1);
    chk("rty5_no_dv", n_dv, 0);
    chk("rty5_stb_issues", n_stb, 5);
    chk("rty5_cyc_low", CYC, 1'b0);
    rty_target = 0;

    // Silent slave timeout
    silent = 1'b1;
    req(0, LOAD_DATA, 3'b010, 32'h1000, 32'h0);
    wait_done("tmo", 40);
    chk("tmo_err", n_err, 1);
    chk("tmo_delay", err_edge - stb_edge, 16);
    chk("tmo_cyc_low", {CYC, STB}, 2'b00);
    silent = 1'b0;

    // ERR together with ACK
    err_mode = 1'b1;
    req(0, LOAD_DATA, 3'b010, 32'h1000, 32'h0);
    wait_done("errack", 20);
    chk("errack_err_dv", {n_err[3:0], n_dv[3:0]}, {4'd1, 4'd0});
    err_mode = 1'b0;

    // Illegal funct3 load and store
    req(0, LOAD_DATA, 3'b011, 32'h1000, 32'h0);
    wait_done("ill_ld", 20);
    chk("ill_ld_result", {n_ack[3:0], n_err[3:0], n_dv[3:0], cyc_seen}, {4'd1, 4'd1, 4'd0, 1'b0});
    req(0, STORE_DATA, 3'b100, 32'h1000, 32'h0);
    wait_done("ill_st", 20);
    chk("ill_st_result", {n_err[3:0], cyc_seen}, {4'd1, 1'b0});

    // No-op request is ignored
    req(0, MEM_NOP, 3'b010, 32'h1000, 32'h0);
    repeat (4) @(negedge clk);
    chk("nop_ignored", {n_ack[3:0], n_err[3:0], n_dv[3:0], cyc_seen}, 13'd0);

    // Reset during beat 2, then a normal request
    req(0, LOAD_DATA, 3'b010, 32'h1003, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_beat2_active", {CYC, STB, CTI_O}, {1'b1, 1'b1, 3'b111});
    rst = 1'b0;
    #1;
    chk("mid_rst_ctrl", {CYC, STB, WE, ack, err, dv}, 64'd0);
    chk("mid_rst_bus", {ADR, SEL_O, CTI_O, ld}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    chk("mid_rst_no_dv", n_dv, 0);
    req(0, LOAD_DATA, 3'b010, 32'h1004, 32'h0);
    wait_done("post_rst", 20);
    chk("post_rst_data", ld, 32'h8877_6655);

    // Non-splitting unit
    req(1, LOAD_DATA, 3'b010, 32'h1002, 32'h0);
    repeat (6) @(negedge clk);
    chk("nosplit_err", {n_err1[3:0], n_dv1[3:0], cyc1_seen}, {4'd1, 4'd0, 1'b0});
    req(1, LOAD_DATA, 3'b010, 32'h1000, 32'h0);
    repeat (6) @(negedge clk);
    chk("nosplit_aligned", {n_dv1[3:0], ld1}, {4'd1, 32'hCAFE_F00D});

    // 64-bit unit split
    req(2, LOAD_DATA, 3'b010, 32'h1006, 32'h0);
    repeat (8) @(negedge clk);
    chk("w64_sel", {b2_sel[0], b2_sel[1]}, {8'hC0, 8'h03});
    chk("w64_adr", {b2_adr[0], b2_adr[1]}, {32'h1000, 32'h1008});
    chk("w64_data", {n_dv2[3:0], ld2}, {4'd1, 32'h9988_8877});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
